// File: rtl/oc8051_cxrom_fetch_arb.sv
// Arbitrates the single cxrom word read port between instruction fetch (IF) and MOVC (MV).
// IF has fixed priority; MV is forced after STARVE_LIM consecutive IF wins, and each ROM access may time out.
module oc8051_cxrom_fetch_arb #(
    parameter int unsigned STARVE_LIM = 4,
    parameter int unsigned TIMEOUT    = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [15:0] if_addr,
    output logic        if_ack,
    output logic [31:0] if_data,
    input  logic        mv_req,
    input  logic [15:0] mv_addr,
    output logic        mv_ack,
    output logic [31:0] mv_data,
    output logic        rom_req,
    output logic [15:0] rom_addr,
    input  logic        rom_ack,
    input  logic [31:0] rom_data,
    output logic        busy,
    output logic        grant_mv,
    output logic        err
);

    localparam int unsigned AW      = 16;
    localparam int unsigned DW      = 32;
    localparam int unsigned SC_W    = $clog2(STARVE_LIM + 1);
    localparam int unsigned TO_W    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam int unsigned TO_LAST = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_RESP  = 2'd2
    } state_t;

    state_t          r_state;
    logic [SC_W-1:0] r_starve_cnt;
    logic [TO_W-1:0] r_to_cnt;
    logic            r_if_ack;
    logic            r_mv_ack;
    logic [DW-1:0]   r_if_data;
    logic [DW-1:0]   r_mv_data;
    logic            r_rom_req;
    logic [AW-1:0]   r_rom_addr;
    logic            r_busy;
    logic            r_grant_mv;
    logic            r_err;

    logic w_pick_mv;
    logic w_timeout;

    // MV wins only when IF is absent or MV has been passed over STARVE_LIM times in a row
    assign w_pick_mv = mv_req && (!if_req || (r_starve_cnt == SC_W'(STARVE_LIM)));
    assign w_timeout = (TIMEOUT != 0) && (r_to_cnt == TO_W'(TO_LAST));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_starve_cnt <= '0;
            r_to_cnt     <= '0;
            r_if_ack     <= 1'b0;
            r_mv_ack     <= 1'b0;
            r_if_data    <= '0;
            r_mv_data    <= '0;
            r_rom_req    <= 1'b0;
            r_rom_addr   <= '0;
            r_busy       <= 1'b0;
            r_grant_mv   <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_if_ack <= 1'b0;
            r_mv_ack <= 1'b0;
            r_err    <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (if_req || mv_req) begin
                        r_state    <= S_ISSUE;
                        r_busy     <= 1'b1;
                        r_rom_req  <= 1'b1;
                        r_grant_mv <= w_pick_mv;
                        r_rom_addr <= w_pick_mv ? mv_addr : if_addr;
                        if (w_pick_mv || !mv_req) begin
                            r_starve_cnt <= '0;
                        end else if (r_starve_cnt != SC_W'(STARVE_LIM)) begin
                            r_starve_cnt <= r_starve_cnt + SC_W'(1);
                        end
                    end
                end
                S_ISSUE: begin
                    r_to_cnt <= r_to_cnt + TO_W'(1);
                    // an ack arriving on the last allowed cycle still counts as success
                    if (rom_ack || w_timeout) begin
                        r_state   <= S_RESP;
                        r_rom_req <= 1'b0;
                        r_to_cnt  <= '0;
                        r_err     <= !rom_ack;
                        if (r_grant_mv) begin
                            r_mv_data <= rom_ack ? rom_data : '0;
                            r_mv_ack  <= 1'b1;
                        end else begin
                            r_if_data <= rom_ack ? rom_data : '0;
                            r_if_ack  <= 1'b1;
                        end
                    end
                end
                S_RESP: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign if_ack   = r_if_ack;
    assign if_data  = r_if_data;
    assign mv_ack   = r_mv_ack;
    assign mv_data  = r_mv_data;
    assign rom_req  = r_rom_req;
    assign rom_addr = r_rom_addr;
    assign busy     = r_busy;
    assign grant_mv = r_grant_mv;
    assign err      = r_err;

endmodule
